cnc_result_collector: RTL

- Downstream stage of the complex number calculator (CNC). Consumes its OUT_VALID/OUT[16:0] result stream and buffers it in a small FIFO.
- Each contiguous run of valid cycles forms one frame. The block saturates each 17-bit signed result to 16 bits and tags the last word of each frame.
- Results are re-presented to the system bus with a valid/ready handshake, so a stalling consumer does not lose CNC results.

---
 rtl/cnc_pkg.sv | 23 ++
 rtl/cnc_sync_fifo.sv | 79 +++++++
 rtl/cnc_result_collector.sv | 137 +++++++++++++
 3 files changed

// File: rtl/cnc_pkg.sv
// ----------------------------------------------------------------------------
// cnc_pkg
// Shared definitions for the CNC result path: the CNC output width, the system
// bus width, the saturation rails and the layout of one buffered result word.
// ----------------------------------------------------------------------------
package cnc_pkg;

    localparam int CNC_OUT_W = 17;
    localparam int BUS_W     = 16;

    localparam logic [BUS_W-1:0] SAT_MAX = 16'h7FFF;
    localparam logic [BUS_W-1:0] SAT_MIN = 16'h8000;

    // One buffered result: saturated data, end-of-frame tag, clipped flag.
    typedef struct packed {
        logic [BUS_W-1:0] data;
        logic             last;
        logic             sat;
    } fifo_entry_t;

    localparam int ENTRY_W = $bits(fifo_entry_t);

endpackage

// File: rtl/cnc_sync_fifo.sv
// ----------------------------------------------------------------------------
// cnc_sync_fifo
// Generic single-clock FIFO with a first-word fall-through head: o_rdata always
// shows the oldest stored entry, so a pop simply advances past it.
//
// Ports
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset (empties the FIFO)
//   i_push   in   write request; honoured when not full, or when full and a
//                 pop happens in the same cycle
//   i_wdata  in   WIDTH-bit entry to write
//   i_pop    in   read request; ignored while empty
//   o_rdata  out  head entry (meaningless while o_empty=1)
//   o_full   out  DEPTH entries stored
//   o_empty  out  no entries stored
//   o_count  out  number of stored entries, 0..DEPTH
// ----------------------------------------------------------------------------
module cnc_sync_fifo #(
    parameter  int WIDTH = 18,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [AW:0]      o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_count = r_count;
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_rdata = r_mem[r_rd_ptr];

    assign w_do_pop  = i_pop && !o_empty;
    // When full, the slot being written is the one the pop is vacating: the
    // head is read combinationally before the write lands at the clock edge.
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; only the pointers and count decide validity.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

endmodule

// File: rtl/cnc_result_collector.sv
// ----------------------------------------------------------------------------
// cnc_result_collector
// Captures the CNC result stream, splits it into frames (one frame per run of
// consecutive valid cycles), saturates each 17-bit signed result to 16 bits,
// tags the last word of every frame and re-presents the words to the bus
// through a small FIFO with a valid/ready handshake.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   CNC OUT_VALID, sampled every cycle (no backpressure)
//   in_data    in   CNC OUT, IN_W-bit signed
//   out_valid  out  head word available
//   out_ready  in   consumer takes the head word when out_valid && out_ready
//   out_data   out  saturated head word
//   out_last   out  head word closes its frame
//   out_sat    out  head word was clipped
//   overflow   out  sticky: a word was dropped on a full FIFO
//   frame_cnt  out  frames whose last word reached the FIFO (or was dropped)
// ----------------------------------------------------------------------------
module cnc_result_collector
    import cnc_pkg::*;
#(
    parameter int IN_W  = CNC_OUT_W,
    parameter int OUT_W = BUS_W,
    parameter int DEPTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_last,
    output logic             out_sat,
    output logic             overflow,
    output logic [CNT_W-1:0] frame_cnt
);

    logic                    r_hold_v;
    logic [IN_W-1:0]         r_hold_data;
    logic                    r_overflow;
    logic [CNT_W-1:0]        r_frame_cnt;
    fifo_entry_t             r_shown;

    logic [IN_W-OUT_W:0]     w_top;
    logic                    w_fits;
    fifo_entry_t             w_push_entry;
    fifo_entry_t             w_head;
    fifo_entry_t             w_view;
    logic                    w_push_req;
    logic                    w_pop;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_drop;
    logic [$clog2(DEPTH):0]  w_count;

    // A held word can only be closed once the following cycle shows whether
    // the run continues, hence the one-word hold stage in front of the FIFO.
    assign w_push_req = r_hold_v;

    // The value fits in OUT_W bits when every bit from the OUT_W sign position
    // upward is a copy of the same sign.
    assign w_top  = r_hold_data[IN_W-1:OUT_W-1];
    assign w_fits = (&w_top) | ~(|w_top);

    always_comb begin
        w_push_entry      = '0;
        w_push_entry.last = ~in_valid;
        if (w_fits) begin
            w_push_entry.data = r_hold_data[OUT_W-1:0];
            w_push_entry.sat  = 1'b0;
        end else if (r_hold_data[IN_W-1]) begin
            w_push_entry.data = SAT_MIN;
            w_push_entry.sat  = 1'b1;
        end else begin
            w_push_entry.data = SAT_MAX;
            w_push_entry.sat  = 1'b1;
        end
    end

    assign w_pop  = out_valid && out_ready;
    assign w_drop = w_push_req && w_full && !w_pop;

    cnc_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push_req),
        .i_wdata (w_push_entry),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_v    <= 1'b0;
            r_hold_data <= '0;
            r_overflow  <= 1'b0;
            r_frame_cnt <= '0;
            r_shown     <= '0;
        end else begin
            r_hold_v <= in_valid;
            if (in_valid) begin
                r_hold_data <= in_data;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            // Counted on the push attempt so a dropped frame end still counts.
            if (w_push_req && !in_valid) begin
                r_frame_cnt <= r_frame_cnt + CNT_W'(1);
            end
            // Remember what the bus last saw so the outputs hold when empty.
            if (!w_empty) begin
                r_shown <= w_head;
            end
        end
    end

    assign w_view = w_empty ? r_shown : w_head;

    assign out_valid = (w_count != '0);
    assign out_data  = w_view.data;
    assign out_last  = w_view.last;
    assign out_sat   = w_view.sat;
    assign overflow  = r_overflow;
    assign frame_cnt = r_frame_cnt;

endmodule
